// File: rtl/alu_pkg.sv
// Shared constants, opcode encoding and FSM state type for the ALU issue/writeback sequencer.
package alu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned NREGS  = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned OP_W   = 4;

   // Opcode encoding shared with the ALU's ALU_Sel input
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
   localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
   localparam logic [OP_W-1:0] OP_SHL  = 4'b0100;
   localparam logic [OP_W-1:0] OP_SHR  = 4'b0101;
   localparam logic [OP_W-1:0] OP_ROL  = 4'b0110;
   localparam logic [OP_W-1:0] OP_ROR  = 4'b0111;
   localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
   localparam logic [OP_W-1:0] OP_NOR  = 4'b1011;
   localparam logic [OP_W-1:0] OP_NAND = 4'b1100;
   localparam logic [OP_W-1:0] OP_XNOR = 4'b1101;
   localparam logic [OP_W-1:0] OP_GT   = 4'b1110;
   localparam logic [OP_W-1:0] OP_EQ   = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Command fields carried from accept through writeback
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] rd;
   } inflight_t;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Register-addressed command handshake between an issuer and the ALU sequencer.
interface alu_reg_sequencer_if;
   import alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [ADDR_W-1:0] cmd_rd;
   logic [ADDR_W-1:0] cmd_rs1;
   logic [ADDR_W-1:0] cmd_rs2;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
      output cmd_ready
   );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: three async read ports, writeback and load writes with writeback priority.
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] rs1_data_c,
   output logic [DATA_W-1:0] rs2_data_c,
   output logic [DATA_W-1:0] dbg_data_c,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] regs [NREGS];

   // Both ports may write different entries in one cycle; same entry resolves to writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (wb_en && (wb_addr == ADDR_W'(i))) begin
               regs[i] <= wb_data;
            end else if (ld_en && (ld_addr == ADDR_W'(i))) begin
               regs[i] <= ld_data;
            end
         end
      end
   end

   assign rs1_data_c = regs[rs1_addr];
   assign rs2_data_c = regs[rs2_addr];
   assign dbg_data_c = regs[dbg_addr];

endmodule

// File: rtl/alu_reg_sequencer.sv
// Issue/writeback stage for an external combinational 8-bit ALU: operand fetch, result capture,
// register writeback and carry/zero/divide-by-zero status.
module alu_reg_sequencer
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   alu_reg_sequencer_if.slave  cmd,
   input  logic                ld_valid,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic [ADDR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_sel,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic                alu_carry,
   output logic                done,
   output logic [DATA_W-1:0]   done_data,
   output logic                flag_c,
   output logic                flag_z,
   output logic                flag_dz
);

   state_t            state, state_nxt;
   inflight_t         infl, infl_nxt;
   logic              c_q, c_nxt;
   logic              dz_q, dz_nxt;
   logic [DATA_W-1:0] alu_a_nxt, alu_b_nxt;
   logic [OP_W-1:0]   alu_sel_nxt;
   logic              done_nxt;
   logic [DATA_W-1:0] done_data_nxt;
   logic              flag_c_nxt, flag_z_nxt, flag_dz_nxt;
   logic              wb_en_c;
   logic              accept_c;
   logic [DATA_W-1:0] rs1_data_c, rs2_data_c;

   // A load in IDLE stalls the command so the two never race for the register file
   assign cmd.cmd_ready = (state == S_IDLE) && !ld_valid;
   assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;

   alu_regfile u_regfile (
      .clk        (clk),
      .rst        (rst),
      .rs1_addr   (cmd.cmd_rs1),
      .rs2_addr   (cmd.cmd_rs2),
      .dbg_addr   (dbg_addr),
      .rs1_data_c (rs1_data_c),
      .rs2_data_c (rs2_data_c),
      .dbg_data_c (dbg_data),
      .wb_en      (wb_en_c),
      .wb_addr    (infl.rd),
      .wb_data    (done_data),
      .ld_en      (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data)
   );

   // Next-state and next-output logic; done_data doubles as the captured result
   always_comb begin
      state_nxt     = state;
      infl_nxt      = infl;
      c_nxt         = c_q;
      dz_nxt        = dz_q;
      alu_a_nxt     = alu_a;
      alu_b_nxt     = alu_b;
      alu_sel_nxt   = alu_sel;
      done_nxt      = 1'b0;
      done_data_nxt = done_data;
      flag_c_nxt    = flag_c;
      flag_z_nxt    = flag_z;
      flag_dz_nxt   = flag_dz;
      wb_en_c       = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept_c) begin
               alu_a_nxt   = rs1_data_c;
               alu_b_nxt   = rs2_data_c;
               alu_sel_nxt = cmd.cmd_op;
               infl_nxt.op = cmd.cmd_op;
               infl_nxt.rd = cmd.cmd_rd;
               state_nxt   = S_EXEC;
            end
         end
         S_EXEC: begin
            done_nxt = 1'b1;
            c_nxt    = alu_carry;
            // ALU output is undefined for a zero divisor; substitute all-ones
            if ((infl.op == OP_DIV) && (alu_b == '0)) begin
               done_data_nxt = '1;
               dz_nxt        = 1'b1;
            end else begin
               done_data_nxt = alu_out;
               dz_nxt        = 1'b0;
            end
            state_nxt = S_WB;
         end
         S_WB: begin
            wb_en_c     = 1'b1;
            flag_z_nxt  = (done_data == '0);
            flag_dz_nxt = dz_q;
            if (infl.op == OP_ADD) begin
               flag_c_nxt = c_q;
            end
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         infl      <= '0;
         c_q       <= 1'b0;
         dz_q      <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         done      <= 1'b0;
         done_data <= '0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         flag_dz   <= 1'b0;
      end else begin
         state     <= state_nxt;
         infl      <= infl_nxt;
         c_q       <= c_nxt;
         dz_q      <= dz_nxt;
         alu_a     <= alu_a_nxt;
         alu_b     <= alu_b_nxt;
         alu_sel   <= alu_sel_nxt;
         done      <= done_nxt;
         done_data <= done_data_nxt;
         flag_c    <= flag_c_nxt;
         flag_z    <= flag_z_nxt;
         flag_dz   <= flag_dz_nxt;
      end
   end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer: behavioural ALU alongside the DUT, scoreboard on done pulses,
// direct checks of registers and flags through the debug port.
module tb_alu_reg_sequencer;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic [DATA_W-1:0] alu_a, alu_b, alu_out;
   logic [OP_W-1:0]   alu_sel;
   logic              alu_carry;
   logic              done;
   logic [DATA_W-1:0] done_data;
   logic              flag_c, flag_z, flag_dz;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_q [$];

   always #5 clk = ~clk;

   alu_reg_sequencer_if bus ();

   alu_reg_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd       (bus),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .done      (done),
      .done_data (done_data),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_dz   (flag_dz)
   );

   // Behavioural stand-in for the external ALU; zero divisor returns a marker value
   function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      logic [7:0] r;
      logic [8:0] t;
      t = {1'b0, a} + {1'b0, b};
      case (s)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: r = 8'(a * b);
         4'h3: r = (b == 8'h00) ? 8'h5A : a / b;
         4'h4: r = a << 1;
         4'h5: r = a >> 1;
         4'h6: r = {a[6:0], a[7]};
         4'h7: r = {a[0], a[7:1]};
         4'h8: r = a & b;
         4'h9: r = a | b;
         4'hA: r = a ^ b;
         4'hB: r = ~(a | b);
         4'hC: r = ~(a & b);
         4'hD: r = ~(a ^ b);
         4'hE: r = (a > b) ? 8'h01 : 8'h00;
         default: r = (a == b) ? 8'h01 : 8'h00;
      endcase
      return {t[8], r};
   endfunction

   always_comb {alu_carry, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got %0h want no done", done_data);
         end else begin
            check("done_data", 32'(done_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      @(posedge clk);
      #1 ld_valid = 1'b0;
   endtask

   task automatic issue(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                        input logic [ADDR_W-1:0] rs2, input logic [DATA_W-1:0] exp, input bit push,
                        output int waited);
      waited = 0;
      @(negedge clk);
      while (!bus.cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.cmd_ready) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: got cmd_ready=0 want 1 within 20 cycles");
      end else begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = op;
         bus.cmd_rd    = rd;
         bus.cmd_rs1   = rs1;
         bus.cmd_rs2   = rs2;
         if (push) exp_q.push_back(exp);
         @(posedge clk);
         #1 bus.cmd_valid = 1'b0;
      end
   endtask

   // Issue, then require done low in EXEC and high in WB, ending in the IDLE cycle after writeback
   task automatic run(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                      input logic [ADDR_W-1:0] rs2, input logic [DATA_W-1:0] exp);
      int w;
      issue(op, rd, rs1, rs2, exp, 1'b1, w);
      @(negedge clk);
      check("latency_exec_done", 32'(done), 0);
      @(negedge clk);
      check("latency_wb_done", 32'(done), 1);
      @(negedge clk);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got done=0 want 1 within 20 cycles");
      end
      @(negedge clk);
   endtask

   task automatic chk_reg(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      dbg_addr = a;
      #1;
      check(name, 32'(dbg_data), 32'(exp));
   endtask

   task automatic chk_flags(input string name, input logic c, input logic z, input logic dz);
      check({name, "_c"},  32'(flag_c),  32'(c));
      check({name, "_z"},  32'(flag_z),  32'(z));
      check({name, "_dz"}, 32'(flag_dz), 32'(dz));
   endtask

   logic [DATA_W-1:0] sweep_exp [16] = '{8'hE1, 8'h69, 8'hAC, 8'h02, 8'h4A, 8'h52, 8'h4B, 8'hD2,
                                         8'h24, 8'hBD, 8'h99, 8'h42, 8'hDB, 8'h66, 8'h01, 8'h00};

   initial begin
      int w;
      rst           = 1'b1;
      ld_valid      = 1'b0;
      ld_addr       = '0;
      ld_data       = '0;
      dbg_addr      = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_rd    = '0;
      bus.cmd_rs1   = '0;
      bus.cmd_rs2   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_done", 32'(done), 0);
      check("rst_done_data", 32'(done_data), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);
      check("rst_alu_sel", 32'(alu_sel), 0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk_flags("rst_flag", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) chk_reg("rst_reg", ADDR_W'(i), 8'h00);
      rst = 1'b0;

      // ADD with carry out
      load(3'd1, 8'hF0);
      load(3'd2, 8'h20);
      run(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h10);
      chk_reg("add_r3", 3'd3, 8'h10);
      chk_flags("add_flag", 1'b1, 1'b0, 1'b0);

      // Divide by zero, then a clean SUB clears dz and leaves carry alone
      load(3'd1, 8'h07);
      load(3'd2, 8'h00);
      run(OP_DIV, 3'd4, 3'd1, 3'd2, 8'hFF);
      chk_reg("div0_r4", 3'd4, 8'hFF);
      chk_flags("div0_flag", 1'b1, 1'b0, 1'b1);
      run(OP_SUB, 3'd5, 3'd1, 3'd1, 8'h00);
      chk_reg("sub_r5", 3'd5, 8'h00);
      chk_flags("sub_flag", 1'b1, 1'b1, 1'b0);

      // Back-to-back dependent ADDs
      load(3'd1, 8'h01);
      load(3'd2, 8'h01);
      issue(OP_ADD, 3'd1, 3'd1, 3'd2, 8'h02, 1'b1, w);
      check("b2b_first_wait", 32'(w), 0);
      issue(OP_ADD, 3'd1, 3'd1, 3'd2, 8'h03, 1'b1, w);
      check("b2b_gap_cycles", 32'(w), 2);
      wait_done();
      chk_reg("b2b_r1", 3'd1, 8'h03);
      chk_flags("b2b_flag", 1'b0, 1'b0, 1'b0);

      // Load and command together in IDLE: load applies, command not accepted
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_ADD;
      bus.cmd_rd    = 3'd7;
      bus.cmd_rs1   = 3'd1;
      bus.cmd_rs2   = 3'd2;
      ld_valid      = 1'b1;
      ld_addr       = 3'd6;
      ld_data       = 8'h66;
      #1 check("ld_blocks_ready", 32'(bus.cmd_ready), 0);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      ld_valid      = 1'b0;
      @(negedge clk);
      check("ld_no_accept", 32'(bus.cmd_ready), 1);
      chk_reg("ld_r6", 3'd6, 8'h66);
      chk_reg("ld_r7_untouched", 3'd7, 8'h00);

      // Loads during EXEC (to a source) and WB (to rd)
      issue(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h04, 1'b1, w);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 8'h55;
      @(posedge clk);
      #1 ld_valid = 1'b0;
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 8'h77;
      @(posedge clk);
      #1 ld_valid = 1'b0;
      @(negedge clk);
      chk_reg("wb_beats_ld_r3", 3'd3, 8'h04);
      chk_reg("exec_ld_r1", 3'd1, 8'h55);

      // Truncating ADD: zero result with carry
      load(3'd1, 8'hFF);
      run(OP_ADD, 3'd6, 3'd1, 3'd2, 8'h00);
      chk_reg("wrap_r6", 3'd6, 8'h00);
      chk_flags("wrap_flag", 1'b1, 1'b1, 1'b0);

      // Reset during EXEC aborts the command
      issue(OP_ADD, 3'd7, 3'd1, 3'd2, 8'h00, 1'b0, w);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
      check("abort_done", 32'(done), 0);
      check("abort_alu_a", 32'(alu_a), 0);
      chk_flags("abort_flag", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) chk_reg("abort_reg", ADDR_W'(i), 8'h00);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 0);
      end

      // Opcode sweep, A=A5 B=3C, plus same-register compares
      load(3'd1, 8'hA5);
      load(3'd2, 8'h3C);
      for (int i = 0; i < 16; i++) begin
         run(OP_W'(i), 3'd0, 3'd1, 3'd2, sweep_exp[i]);
         chk_reg("sweep_r0", 3'd0, sweep_exp[i]);
      end
      run(OP_EQ, 3'd0, 3'd1, 3'd1, 8'h01);
      run(OP_GT, 3'd0, 3'd1, 3'd1, 8'h00);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
